// File: rtl/apb_master_fsm_if.sv
// ---------------------------------------------------------------------------
// apb_master_fsm_if
//   Bundles the command port, the response port and the APB bus signals of
//   the apb_master_fsm requester.
//
//   Command  : i_CMD_VALID/o_CMD_READY handshake with WRITE, ADDR, WDATA, SEL
//   Response : o_RSP_VALID/i_RSP_READY handshake with RDATA, ERR, TIMEOUT
//   APB      : o_PSEL (one-hot), o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA out;
//              i_PREADY, i_PRDATA, i_PSLVERR in from the slave read mux
//
//   modport master : the requester (drives the o_* signals)
//   modport slave  : everything around it (drives the i_* signals)
// ---------------------------------------------------------------------------
interface apb_master_fsm_if #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = 2
);

  logic                  i_CMD_VALID;
  logic                  o_CMD_READY;
  logic                  i_CMD_WRITE;
  logic [ADDR_WIDTH-1:0] i_CMD_ADDR;
  logic [DATA_WIDTH-1:0] i_CMD_WDATA;
  logic [SEL_WIDTH-1:0]  i_CMD_SEL;

  logic                  o_RSP_VALID;
  logic                  i_RSP_READY;
  logic [DATA_WIDTH-1:0] o_RSP_RDATA;
  logic                  o_RSP_ERR;
  logic                  o_RSP_TIMEOUT;

  logic [SEL_WIDTH-1:0]  o_PSEL;
  logic                  o_PENABLE;
  logic                  o_PWRITE;
  logic [ADDR_WIDTH-1:0] o_PADDR;
  logic [DATA_WIDTH-1:0] o_PWDATA;
  logic                  i_PREADY;
  logic [DATA_WIDTH-1:0] i_PRDATA;
  logic                  i_PSLVERR;

  modport master (
    input  i_CMD_VALID, i_CMD_WRITE, i_CMD_ADDR, i_CMD_WDATA, i_CMD_SEL,
    input  i_RSP_READY, i_PREADY, i_PRDATA, i_PSLVERR,
    output o_CMD_READY, o_RSP_VALID, o_RSP_RDATA, o_RSP_ERR, o_RSP_TIMEOUT,
    output o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
  );

  modport slave (
    output i_CMD_VALID, i_CMD_WRITE, i_CMD_ADDR, i_CMD_WDATA, i_CMD_SEL,
    output i_RSP_READY, i_PREADY, i_PRDATA, i_PSLVERR,
    input  o_CMD_READY, o_RSP_VALID, o_RSP_RDATA, o_RSP_ERR, o_RSP_TIMEOUT,
    input  o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
  );

endinterface

// File: rtl/apb_master_fsm.sv
// ---------------------------------------------------------------------------
// apb_master_fsm
//   APB requester stage. Takes one command at a time, runs the APB
//   SETUP/ACCESS sequence towards a one-hot selected slave and returns a
//   single response beat carrying read data plus error/timeout flags.
//
//   i_PCLK    : bus clock
//   i_PRESETn : asynchronous active-low reset; drops any in-flight command
//   bus       : apb_master_fsm_if.master (command, response and APB signals)
//
//   All APB and response outputs come straight from registers. o_CMD_READY
//   is high only in IDLE while reset is released.
// ---------------------------------------------------------------------------
module apb_master_fsm #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic             i_PCLK,
  input  logic             i_PRESETn,
  apb_master_fsm_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Wait counter just wide enough to hold TIMEOUT; one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspRdata_q, rspRdata_d;
  logic                  rspErr_q, rspErr_d;
  logic                  rspTimeout_q, rspTimeout_d;
  logic [CNT_W-1:0]      waitCnt_q, waitCnt_d;
  logic                  endXfer;

  // State and output registers; reset returns everything to an idle bus.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q      <= IDLE;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      waitCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rspValid_q   <= rspValid_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      rspTimeout_q <= rspTimeout_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  // Next-state logic. Everything holds by default so the APB fields stay
  // frozen from SETUP through the final ACCESS cycle and the response stays
  // stable while the consumer back-pressures.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rspValid_d   = rspValid_q;
    rspRdata_d   = rspRdata_q;
    rspErr_d     = rspErr_q;
    rspTimeout_d = rspTimeout_q;
    waitCnt_d    = waitCnt_q;
    endXfer      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_CMD_VALID) begin
          if ($onehot(bus.i_CMD_SEL)) begin
            state_d   = SETUP;
            psel_d    = bus.i_CMD_SEL;
            pwrite_d  = bus.i_CMD_WRITE;
            paddr_d   = bus.i_CMD_ADDR;
            pwdata_d  = bus.i_CMD_WDATA;
            penable_d = 1'b0;
          end else begin
            // Zero or multi-hot select: answer with an error, never touch APB.
            state_d      = RESP;
            rspValid_d   = 1'b1;
            rspRdata_d   = '0;
            rspErr_d     = 1'b1;
            rspTimeout_d = 1'b0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        waitCnt_d = '0;
      end

      ACCESS: begin
        // PREADY is checked first so it wins over a coincident timeout.
        if (bus.i_PREADY) begin
          state_d      = RESP;
          rspValid_d   = 1'b1;
          rspErr_d     = bus.i_PSLVERR;
          rspTimeout_d = 1'b0;
          // Writes and slave errors return no data.
          rspRdata_d   = (pwrite_q || bus.i_PSLVERR) ? '0 : bus.i_PRDATA;
          endXfer      = 1'b1;
        end else begin
          if (waitCnt_q != CNT_MAX) waitCnt_d = waitCnt_q + CNT_W'(1);
          // Counter reads TIMEOUT-1 during the TIMEOUT-th wait cycle.
          if ((TIMEOUT != 0) && (waitCnt_q == CNT_LAST)) begin
            state_d      = RESP;
            rspValid_d   = 1'b1;
            rspErr_d     = 1'b1;
            rspTimeout_d = 1'b1;
            rspRdata_d   = '0;
            endXfer      = 1'b1;
          end
        end
      end

      RESP: begin
        if (bus.i_RSP_READY) begin
          state_d    = IDLE;
          rspValid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Leaving ACCESS returns the whole APB bus to zero.
    if (endXfer) begin
      psel_d    = '0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
    end
  end

  // Ready is gated by reset so nothing can be accepted while it is held.
  assign bus.o_CMD_READY   = (state_q == IDLE) && i_PRESETn;
  assign bus.o_RSP_VALID   = rspValid_q;
  assign bus.o_RSP_RDATA   = rspRdata_q;
  assign bus.o_RSP_ERR     = rspErr_q;
  assign bus.o_RSP_TIMEOUT = rspTimeout_q;
  assign bus.o_PSEL        = psel_q;
  assign bus.o_PENABLE     = penable_q;
  assign bus.o_PWRITE      = pwrite_q;
  assign bus.o_PADDR       = paddr_q;
  assign bus.o_PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// ---------------------------------------------------------------------------
// tb_apb_master_fsm
//   Directed bench for apb_master_fsm. A transaction-level model predicts
//   every registered output each cycle; directed sequences add hand-computed
//   latency, access-length and response-data expectations.
// ---------------------------------------------------------------------------
module tb_apb_master_fsm;

  localparam int DW = 3;
  localparam int AW = 16;
  localparam int SW = 2;
  localparam int TO = 16;
  localparam int MAX_WAIT = 200;

  logic clk = 1'b0;
  logic rstN;
  int   total = 0;
  int   bad = 0;

  apb_master_fsm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

  apb_master_fsm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .i_PCLK   (clk),
    .i_PRESETn(rstN),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Transaction model: a command is either in flight (one setup cycle, then
  // access cycles counted until ready or timeout) or waiting as a response.
  bit              mInFlight, mInAccess, mRspPending;
  logic            mWrite;
  logic [AW-1:0]   mAddr;
  logic [DW-1:0]   mWdata, mRdata;
  logic [SW-1:0]   mSel;
  bit              mErr, mTo;
  int              mAccessCount, mLastAccessLen;

  task automatic modelClear();
    mInFlight = 1'b0; mInAccess = 1'b0; mRspPending = 1'b0;
    mAccessCount = 0;
  endtask

  task automatic modelRespond(input logic [DW-1:0] data, input bit err, input bit tout);
    mInFlight = 1'b0; mInAccess = 1'b0; mRspPending = 1'b1;
    mRdata = data; mErr = err; mTo = tout;
    mLastAccessLen = mAccessCount;
  endtask

  task automatic modelStep();
    if (mRspPending) begin
      if (bus.i_RSP_READY) mRspPending = 1'b0;
    end else if (mInFlight) begin
      if (!mInAccess) begin
        mInAccess = 1'b1;
        mAccessCount = 0;
      end else begin
        mAccessCount++;
        if (bus.i_PREADY)
          modelRespond((mWrite || bus.i_PSLVERR) ? '0 : bus.i_PRDATA, bus.i_PSLVERR, 1'b0);
        else if (TO != 0 && mAccessCount == TO)
          modelRespond('0, 1'b1, 1'b1);
      end
    end else if (bus.i_CMD_VALID) begin
      if ($countones(bus.i_CMD_SEL) == 1) begin
        mInFlight = 1'b1; mInAccess = 1'b0;
        mWrite = bus.i_CMD_WRITE; mAddr = bus.i_CMD_ADDR;
        mWdata = bus.i_CMD_WDATA; mSel = bus.i_CMD_SEL;
      end else begin
        mAccessCount = 0;
        modelRespond('0, 1'b1, 1'b0);
      end
    end
  endtask

  initial begin
    modelClear();
    mLastAccessLen = 0;
    forever begin
      @(posedge clk or negedge rstN);
      if (rstN !== 1'b1) modelClear();
      else modelStep();
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rstN !== 1'b1) begin
        checkOutput("rstPSEL", 32'(bus.o_PSEL), 0);
        checkOutput("rstPENABLE", 32'(bus.o_PENABLE), 0);
        checkOutput("rstPWRITE", 32'(bus.o_PWRITE), 0);
        checkOutput("rstPADDR", 32'(bus.o_PADDR), 0);
        checkOutput("rstPWDATA", 32'(bus.o_PWDATA), 0);
        checkOutput("rstRSP_VALID", 32'(bus.o_RSP_VALID), 0);
        checkOutput("rstRSP_RDATA", 32'(bus.o_RSP_RDATA), 0);
        checkOutput("rstRSP_ERR", 32'(bus.o_RSP_ERR), 0);
        checkOutput("rstRSP_TIMEOUT", 32'(bus.o_RSP_TIMEOUT), 0);
        checkOutput("rstCMD_READY", 32'(bus.o_CMD_READY), 0);
      end else begin
        checkOutput("PSEL", 32'(bus.o_PSEL), 32'(mInFlight ? mSel : '0));
        checkOutput("PENABLE", 32'(bus.o_PENABLE), 32'(mInFlight && mInAccess));
        checkOutput("PWRITE", 32'(bus.o_PWRITE), 32'(mInFlight ? mWrite : 1'b0));
        checkOutput("PADDR", 32'(bus.o_PADDR), 32'(mInFlight ? mAddr : '0));
        checkOutput("PWDATA", 32'(bus.o_PWDATA), 32'(mInFlight ? mWdata : '0));
        checkOutput("CMD_READY", 32'(bus.o_CMD_READY), 32'(!mInFlight && !mRspPending));
        checkOutput("RSP_VALID", 32'(bus.o_RSP_VALID), 32'(mRspPending));
        if (mRspPending) begin
          checkOutput("RSP_RDATA", 32'(bus.o_RSP_RDATA), 32'(mRdata));
          checkOutput("RSP_ERR", 32'(bus.o_RSP_ERR), 32'(mErr));
          checkOutput("RSP_TIMEOUT", 32'(bus.o_RSP_TIMEOUT), 32'(mTo));
        end
      end
    end
  end

  // Slave responder: PREADY low for slaveWait access cycles, then high.
  // Outside a ready cycle it drives junk data and PSLVERR=1 on purpose.
  int            slaveWait = 0;
  logic [DW-1:0] slaveData = '0;
  bit            slaveErr = 1'b0;
  int            penCycles = 0;
  bit            pselSeen = 1'b0;

  initial begin
    bus.i_PREADY = 1'b0; bus.i_PRDATA = 3'b111; bus.i_PSLVERR = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.o_PENABLE === 1'b1) begin
        penCycles++;
        if (penCycles > slaveWait) begin
          bus.i_PREADY = 1'b1; bus.i_PRDATA = slaveData; bus.i_PSLVERR = slaveErr;
        end else begin
          bus.i_PREADY = 1'b0; bus.i_PRDATA = 3'b111; bus.i_PSLVERR = 1'b1;
        end
      end else begin
        bus.i_PREADY = 1'b0; bus.i_PRDATA = 3'b111; bus.i_PSLVERR = 1'b1;
      end
      if (bus.o_PSEL !== '0) pselSeen = 1'b1;
    end
  end

  logic [DW-1:0] rspD;
  bit            rspE, rspT;
  int            lat;

  // Issues one command (called right after a falling edge), waits for its
  // acceptance and then for the response; returns accept-to-valid latency.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, input logic [SW-1:0] sel,
                               input int waitCycles, input logic [DW-1:0] rd,
                               input bit serr, output int latency);
    int n;
    slaveWait = waitCycles; slaveData = rd; slaveErr = serr;
    penCycles = 0; pselSeen = 1'b0;
    bus.i_CMD_VALID = 1'b1; bus.i_CMD_WRITE = wr; bus.i_CMD_ADDR = addr;
    bus.i_CMD_WDATA = wd; bus.i_CMD_SEL = sel;
    n = 0;
    while (bus.o_CMD_READY !== 1'b1 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmdAccepted", 32'(bus.o_CMD_READY), 1);
    @(negedge clk);
    bus.i_CMD_VALID = 1'b0;
    latency = 1;
    while (bus.o_RSP_VALID !== 1'b1 && latency < MAX_WAIT) begin
      @(negedge clk);
      latency++;
    end
    checkOutput("rspArrived", 32'(bus.o_RSP_VALID), 1);
    rspD = bus.o_RSP_RDATA; rspE = bus.o_RSP_ERR; rspT = bus.o_RSP_TIMEOUT;
  endtask

  task automatic releaseResponse();
    bus.i_RSP_READY = 1'b1;
    @(negedge clk);
    bus.i_RSP_READY = 1'b0;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    bus.i_CMD_VALID = 1'b1; bus.i_CMD_WRITE = 1'b1; bus.i_CMD_ADDR = 16'h00AA;
    bus.i_CMD_WDATA = 3'b001; bus.i_CMD_SEL = 2'b01; bus.i_RSP_READY = 1'b0;

    // Reset: nothing accepted even with a valid command waiting.
    repeat (3) @(negedge clk);
    checkOutput("resetCmdReady", 32'(bus.o_CMD_READY), 0);
    bus.i_CMD_VALID = 1'b0;
    #2 rstN = 1'b1;
    @(negedge clk);
    checkOutput("idleCmdReady", 32'(bus.o_CMD_READY), 1);

    // Zero-wait write.
    applyStimulus(1'b1, 16'h1234, 3'b101, 2'b01, 0, 3'b010, 1'b0, lat);
    checkOutput("wrLatency", 32'(lat), 3);
    checkOutput("wrAccessLen", 32'(penCycles), 1);
    checkOutput("wrModelLen", 32'(mLastAccessLen), 1);
    checkOutput("wrRdata", 32'(rspD), 0);
    checkOutput("wrErr", 32'(rspE), 0);
    releaseResponse();

    // Read with three wait states.
    applyStimulus(1'b0, 16'h0F0E, 3'b000, 2'b10, 3, 3'b110, 1'b0, lat);
    checkOutput("rdWaitLatency", 32'(lat), 6);
    checkOutput("rdWaitAccessLen", 32'(penCycles), 4);
    checkOutput("rdWaitModelLen", 32'(mLastAccessLen), 4);
    checkOutput("rdWaitRdata", 32'(rspD), 3'b110);
    checkOutput("rdWaitErr", 32'(rspE), 0);
    releaseResponse();

    // Slave never ready: aborted after exactly TO access cycles.
    applyStimulus(1'b0, 16'h4321, 3'b000, 2'b01, 1000, 3'b101, 1'b0, lat);
    checkOutput("toAccessLen", 32'(penCycles), 16);
    checkOutput("toModelLen", 32'(mLastAccessLen), 16);
    checkOutput("toLatency", 32'(lat), 18);
    checkOutput("toPselCleared", 32'(bus.o_PSEL), 0);
    checkOutput("toRdata", 32'(rspD), 0);
    checkOutput("toErr", 32'(rspE), 1);
    checkOutput("toFlag", 32'(rspT), 1);
    releaseResponse();

    // Bad selects: multi-hot then zero.
    applyStimulus(1'b0, 16'h0001, 3'b000, 2'b11, 0, 3'b111, 1'b0, lat);
    checkOutput("sel11Latency", 32'(lat), 1);
    checkOutput("sel11NoPsel", 32'(pselSeen), 0);
    checkOutput("sel11Err", 32'(rspE), 1);
    checkOutput("sel11Flag", 32'(rspT), 0);
    releaseResponse();
    applyStimulus(1'b1, 16'h0002, 3'b011, 2'b00, 0, 3'b111, 1'b0, lat);
    checkOutput("sel00Latency", 32'(lat), 1);
    checkOutput("sel00NoPsel", 32'(pselSeen), 0);
    checkOutput("sel00Err", 32'(rspE), 1);
    checkOutput("sel00Flag", 32'(rspT), 0);
    releaseResponse();

    // Slave error on a read.
    applyStimulus(1'b0, 16'h00FF, 3'b000, 2'b01, 0, 3'b011, 1'b1, lat);
    checkOutput("slvErrErr", 32'(rspE), 1);
    checkOutput("slvErrFlag", 32'(rspT), 0);
    checkOutput("slvErrLatency", 32'(lat), 3);
    releaseResponse();

    // Response back-pressure with the next command already waiting.
    applyStimulus(1'b0, 16'h2222, 3'b000, 2'b10, 1, 3'b010, 1'b0, lat);
    checkOutput("bpLatency", 32'(lat), 4);
    bus.i_CMD_VALID = 1'b1; bus.i_CMD_WRITE = 1'b1; bus.i_CMD_ADDR = 16'hBEEF;
    bus.i_CMD_WDATA = 3'b011; bus.i_CMD_SEL = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpCmdReady", 32'(bus.o_CMD_READY), 0);
      checkOutput("bpValid", 32'(bus.o_RSP_VALID), 1);
      checkOutput("bpRdata", 32'(bus.o_RSP_RDATA), 3'b010);
    end
    releaseResponse();
    applyStimulus(1'b1, 16'hBEEF, 3'b011, 2'b01, 2, 3'b000, 1'b0, lat);
    checkOutput("bpNextLatency", 32'(lat), 5);
    checkOutput("bpNextErr", 32'(rspE), 0);
    releaseResponse();

    // Reset in the middle of ACCESS drops the command without a response.
    slaveWait = 1000; penCycles = 0;
    bus.i_CMD_VALID = 1'b1; bus.i_CMD_WRITE = 1'b0; bus.i_CMD_ADDR = 16'h5A5A;
    bus.i_CMD_SEL = 2'b10;
    @(negedge clk);
    bus.i_CMD_VALID = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midPenableBefore", 32'(bus.o_PENABLE), 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midRstPsel", 32'(bus.o_PSEL), 0);
    checkOutput("midRstPenable", 32'(bus.o_PENABLE), 0);
    repeat (2) @(negedge clk);
    #2 rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("midNoRsp", 32'(bus.o_RSP_VALID), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- APB requester stage that sits upstream of the APB slave read/ready mux.
- Accepts one command at a time on a valid/ready command port and runs the APB SETUP/ACCESS protocol with a one-hot slave select.
- Collects PREADY/PRDATA/PSLVERR from the mux and returns a single response beat with error and timeout flags.

Parameters:
- DATA_WIDTH, 3, PWDATA/PRDATA width (matches slave mux).
- ADDR_WIDTH, 16, PADDR width.
- SEL_WIDTH, 2, number of slaves; PSEL is one-hot of this width.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables timeout.

Ports:
- i_PCLK  in  1  bus clock.
- i_PRESETn  in  1  asynchronous active-low reset.
- i_CMD_VALID  in  1  command present.
- o_CMD_READY  out  1  command accepted this cycle when high with valid.
- i_CMD_WRITE  in  1  1=write, 0=read.
- i_CMD_ADDR  in  ADDR_WIDTH  target address.
- i_CMD_WDATA  in  DATA_WIDTH  write data.
- i_CMD_SEL  in  SEL_WIDTH  one-hot slave select.
- o_RSP_VALID  out  1  response present.
- i_RSP_READY  in  1  response consumed.
- o_RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and errors.
- o_RSP_ERR  out  1  slave error, bad select, or timeout.
- o_RSP_TIMEOUT  out  1  error cause was timeout.
- o_PSEL  out  SEL_WIDTH  APB select.
- o_PENABLE  out  1  APB enable.
- o_PWRITE  out  1  APB direction.
- o_PADDR  out  ADDR_WIDTH  APB address.
- o_PWDATA  out  DATA_WIDTH  APB write data.
- i_PREADY  in  1  ready from slave mux.
- i_PRDATA  in  DATA_WIDTH  read data from slave mux.
- i_PSLVERR  in  1  error from slave mux.

Behaviour:
- Single clock i_PCLK; reset i_PRESETn asynchronous, active-low.
- Reset: state IDLE. o_PSEL=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=0, o_PWDATA=0, o_RSP_VALID=0, o_RSP_RDATA=0, o_RSP_ERR=0, o_RSP_TIMEOUT=0, timeout counter=0.
- o_CMD_READY = (state==IDLE). No command is accepted while i_PRESETn is low.
- All APB and response outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE -> SETUP on i_CMD_VALID when i_CMD_SEL is exactly one-hot.
  - Capture WRITE/ADDR/WDATA/SEL into o_PWRITE/o_PADDR/o_PWDATA/o_PSEL.
  - o_PENABLE=0.
- IDLE -> RESP on i_CMD_VALID when i_CMD_SEL is zero or multi-hot.
  - No APB activity; o_PSEL stays 0.
  - Response: ERR=1, TIMEOUT=0, RDATA=0.
- SETUP -> ACCESS always after 1 cycle. o_PENABLE=1; counter cleared to 0.
- ACCESS with i_PREADY=1 -> RESP.
  - Capture RDATA = i_PRDATA on read, 0 on write.
  - ERR = i_PSLVERR; TIMEOUT=0.
  - Clear o_PSEL, o_PENABLE, o_PADDR, o_PWDATA, o_PWRITE to 0.
- ACCESS with i_PREADY=0: counter increments.
  - If TIMEOUT!=0 and counter==TIMEOUT-1, go to RESP with ERR=1, TIMEOUT=1, RDATA=0, and clear APB outputs as above.
  - The ACCESS phase therefore lasts at most TIMEOUT cycles.
- PREADY and timeout in the same cycle: PREADY wins (normal completion).
- APB outputs are held constant from SETUP through the last ACCESS cycle.
- RESP: o_RSP_VALID=1. RDATA/ERR/TIMEOUT are stable until i_RSP_READY=1, then IDLE with o_RSP_VALID=0.
- No new command is accepted while in RESP.
- Latency with zero-wait slave: accept edge N; SETUP cycle N+1; ACCESS cycle N+2; o_RSP_VALID high cycle N+3.
- Minimum command-to-command spacing: 4 cycles.
- Counter width: clog2(TIMEOUT+1), minimum 1 bit; it does not wrap.
- Reset asserted mid-transfer immediately forces o_PSEL/o_PENABLE to 0 and state to IDLE. The in-flight command is dropped with no response.
- i_PRDATA/i_PSLVERR are ignored outside ACCESS cycles with i_PREADY=1.

Test Plan:
- Write, SEL=01, ADDR=0x1234, WDATA=3'b101, PREADY=1 in first ACCESS -> expected response:
  - one SETUP cycle (PSEL=01, PENABLE=0), then one ACCESS cycle (PENABLE=1, PADDR=0x1234, PWDATA=101);
  - RSP_VALID next cycle with ERR=0 and RDATA=0.
- Read, SEL=10, PREADY low 3 cycles then high with PRDATA=3'b110 -> ACCESS lasts 4 cycles, response has RDATA=110 and ERR=0.
- Read, SEL=01, PREADY held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then PSEL=0 and response with ERR=1, TIMEOUT=1, RDATA=0.
- Command with SEL=2'b11, then with SEL=2'b00 -> PSEL never asserted; RSP_VALID the cycle after accept with ERR=1 and TIMEOUT=0.
- Read with PREADY=1, PSLVERR=1, PRDATA=3'b011 -> ERR=1, TIMEOUT=0.
- Response backpressure and mid-transfer reset:
  - Hold RSP_READY low 5 cycles -> RSP fields stable and CMD_READY=0 throughout; accept only after RSP_READY=1.
  - Assert PRESETn=0 during ACCESS -> PSEL/PENABLE go to 0 immediately and no response is produced.
